calc1_port_driver: RTL and testbench

//   Upstream request sequencer for one calc1 requester port. Accepts a complete operation
//   (cmd, op1, op2) on a valid/ready host interface. Serialises it into calc1's two-cycle
//   cmd/data protocol. Waits for the calc1 response, with a timeout. Returns resp/data plus a

---
 rtl/calc1_port_driver.sv | 142 ++++++++++++++
 tb/tb_calc1_port_driver.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/calc1_port_driver.sv
// Request sequencer for one calc1 requester port: serialises a host operation into
// calc1's two-cycle cmd/data protocol and returns the response with a latency count.
module calc1_port_driver #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        c_clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_cmd,
    input  logic [31:0] req_op1,
    input  logic [31:0] req_op2,
    output logic [3:0]  cmd_out,
    output logic [31:0] data_out,
    input  logic [1:0]  calc_resp_in,
    input  logic [31:0] calc_data_in,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [1:0]  rsp_resp,
    output logic [31:0] rsp_data,
    output logic [7:0]  rsp_latency,
    output logic        spurious_resp
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SEND1 = 3'd1,
        S_SEND2 = 3'd2,
        S_WAIT  = 3'd3,
        S_HOLD  = 3'd4
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0] TIMEOUT_LAT  = (TIMEOUT_CYCLES > 255) ? 8'd255 : 8'(TIMEOUT_CYCLES);

    state_t      state_reg, state_next;
    logic [3:0]  cmd_reg, cmd_next;
    logic [31:0] op1_reg, op1_next;
    logic [31:0] op2_reg, op2_next;
    logic [7:0]  count_reg, count_next;
    logic [1:0]  resp_reg, resp_next;
    logic [31:0] data_reg, data_next;
    logic [7:0]  lat_reg, lat_next;
    logic        spurious_reg, spurious_next;

    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= S_IDLE;
            cmd_reg      <= '0;
            op1_reg      <= '0;
            op2_reg      <= '0;
            count_reg    <= '0;
            resp_reg     <= '0;
            data_reg     <= '0;
            lat_reg      <= '0;
            spurious_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cmd_reg      <= cmd_next;
            op1_reg      <= op1_next;
            op2_reg      <= op2_next;
            count_reg    <= count_next;
            resp_reg     <= resp_next;
            data_reg     <= data_next;
            lat_reg      <= lat_next;
            spurious_reg <= spurious_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cmd_next      = cmd_reg;
        op1_next      = op1_reg;
        op2_next      = op2_reg;
        count_next    = count_reg;
        resp_next     = resp_reg;
        data_next     = data_reg;
        lat_next      = lat_reg;
        // A response is only legal while waiting; anything else is flagged but ignored.
        spurious_next = spurious_reg | ((state_reg != S_WAIT) && (calc_resp_in != 2'd0));

        case (state_reg)
            S_IDLE: begin
                if (req_valid) begin
                    cmd_next = req_cmd;
                    op1_next = req_op1;
                    op2_next = req_op2;
                    if (req_cmd != 4'd0) begin
                        state_next = S_SEND1;
                    end else begin
                        resp_next  = 2'd0;
                        data_next  = '0;
                        lat_next   = '0;
                        state_next = S_HOLD;
                    end
                end
            end
            S_SEND1: state_next = S_SEND2;
            S_SEND2: begin
                count_next = '0;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                count_next = (count_reg == 8'hFF) ? count_reg : count_reg + 8'd1;
                if (calc_resp_in != 2'd0) begin
                    resp_next  = calc_resp_in;
                    data_next  = (calc_resp_in == 2'd1) ? calc_data_in : '0;
                    lat_next   = count_reg;
                    state_next = S_HOLD;
                end else if (count_reg == TIMEOUT_LAST) begin
                    resp_next  = 2'd3;
                    data_next  = '0;
                    lat_next   = TIMEOUT_LAT;
                    state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (rsp_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_out  = '0;
        data_out = '0;
        if (state_reg == S_SEND1) begin
            cmd_out  = cmd_reg;
            data_out = op1_reg;
        end else if (state_reg == S_SEND2) begin
            data_out = op2_reg;
        end
    end

    assign req_ready     = (state_reg == S_IDLE);
    assign rsp_valid     = (state_reg == S_HOLD);
    assign rsp_resp      = resp_reg;
    assign rsp_data      = data_reg;
    assign rsp_latency   = lat_reg;
    assign spurious_resp = spurious_reg;

endmodule

// File: tb/tb_calc1_port_driver.sv
// Bench for calc1_port_driver: a behavioural calc1 stub answers on the bus, and the
// expected outcome of each operation is derived from the request with plain arithmetic.
module tb_calc1_port_driver;

    localparam int TO = 64;

    logic        c_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_cmd = '0;
    logic [31:0] req_op1 = '0;
    logic [31:0] req_op2 = '0;
    logic [3:0]  cmd_out;
    logic [31:0] data_out;
    logic [1:0]  calc_resp_in = '0;
    logic [31:0] calc_data_in = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [1:0]  rsp_resp;
    logic [31:0] rsp_data;
    logic [7:0]  rsp_latency;
    logic        spurious_resp;

    int   checks = 0;
    int   errors = 0;
    logic exp_spurious = 1'b0;

    calc1_port_driver #(.TIMEOUT_CYCLES(TO)) dut (
        .c_clk        (c_clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_cmd      (req_cmd),
        .req_op1      (req_op1),
        .req_op2      (req_op2),
        .cmd_out      (cmd_out),
        .data_out     (data_out),
        .calc_resp_in (calc_resp_in),
        .calc_data_in (calc_data_in),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_resp     (rsp_resp),
        .rsp_data     (rsp_data),
        .rsp_latency  (rsp_latency),
        .spurious_resp(spurious_resp)
    );

    always #5 c_clk = ~c_clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // calc1 behaviour: overflow/underflow and unknown commands report error 2.
    function automatic void calc_ref(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                     output logic [1:0] r, output logic [31:0] d);
        logic [32:0] s;
        r = 2'd2;
        d = '0;
        case (c)
            4'd1: begin
                s = {1'b0, a} + {1'b0, b};
                if (!s[32]) begin r = 2'd1; d = s[31:0]; end
            end
            4'd2: if (b <= a) begin r = 2'd1; d = a - b; end
            4'd5: begin r = 2'd1; d = a << b[4:0]; end
            4'd6: begin r = 2'd1; d = a >> b[4:0]; end
            default: begin r = 2'd2; d = '0; end
        endcase
    endfunction

    // Runs one operation starting at a negedge in IDLE; delay >= TO means calc1 never answers.
    task automatic run_op(input logic [3:0] cmd, input logic [31:0] op1, input logic [31:0] op2,
                          input int delay, input int stall);
        int          j;
        int          exp_j;
        logic [1:0]  stub_resp, exp_resp;
        logic [31:0] stub_data, exp_data;
        logic [7:0]  exp_lat;
        logic [3:0]  seen_cmd;
        logic [31:0] seen_op1, seen_op2;
        check("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_cmd   = cmd;
        req_op1   = op1;
        req_op2   = op2;
        @(negedge c_clk);
        req_valid = 1'b0;
        req_cmd   = 4'($urandom);
        req_op1   = $urandom;
        req_op2   = $urandom;
        j = 0;
        if (cmd == 4'd0) begin
            exp_resp = 2'd0;
            exp_data = '0;
            exp_lat  = '0;
            check("nop_cmd_out", 32'(cmd_out), 32'd0);
            check("nop_data_out", data_out, 32'd0);
        end else begin
            check("send1_cmd", 32'(cmd_out), 32'(cmd));
            check("send1_data", data_out, op1);
            check("send1_ready", 32'(req_ready), 32'd0);
            seen_cmd = cmd_out;
            seen_op1 = data_out;
            @(negedge c_clk);
            check("send2_cmd", 32'(cmd_out), 32'd0);
            check("send2_data", data_out, op2);
            seen_op2 = data_out;
            calc_ref(seen_cmd, seen_op1, seen_op2, stub_resp, stub_data);
            calc_ref(cmd, op1, op2, exp_resp, exp_data);
            if (delay < TO) begin
                exp_lat = 8'(delay);
                exp_j   = 3 + delay;
            end else begin
                exp_resp = 2'd3;
                exp_data = '0;
                exp_lat  = 8'(TO);
                exp_j    = 2 + TO;
            end
            j = 2;
            @(negedge c_clk);
            while (!rsp_valid && j < 2 + TO + 4) begin
                check("wait_cmd", 32'(cmd_out), 32'd0);
                check("wait_data", data_out, 32'd0);
                if (j - 2 == delay) begin
                    calc_resp_in = stub_resp;
                    calc_data_in = (stub_resp == 2'd1) ? stub_data : $urandom;
                end
                @(negedge c_clk);
                calc_resp_in = 2'd0;
                calc_data_in = $urandom;
                j++;
            end
            check("rsp_arrival", 32'(j), 32'(exp_j));
        end
        for (int s = 0; s <= stall; s++) begin
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_resp", 32'(rsp_resp), 32'(exp_resp));
            check("hold_data", rsp_data, exp_data);
            check("hold_latency", 32'(rsp_latency), 32'(exp_lat));
            check("hold_req_ready", 32'(req_ready), 32'd0);
            if (s == stall) rsp_ready = 1'b1;
            @(negedge c_clk);
        end
        rsp_ready = 1'b0;
        check("release_valid", 32'(rsp_valid), 32'd0);
        check("release_req_ready", 32'(req_ready), 32'd1);
        check("spurious", 32'(spurious_resp), 32'(exp_spurious));
        $display("op cmd=%0d op1=%08h op2=%08h delay=%0d stall=%0d -> resp=%0d data=%08h lat=%0d",
                 cmd, op1, op2, delay, stall, exp_resp, exp_data, exp_lat);
    endtask

    initial begin
        logic [3:0] cmd_tab [11];
        logic [3:0] rc;
        logic [31:0] ra, rb;
        int rd;
        cmd_tab = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd5, 4'd6, 4'd3, 4'd4, 4'd7, 4'd15};

        // Reset state
        repeat (3) @(negedge c_clk);
        check("rst_cmd_out", 32'(cmd_out), 32'd0);
        check("rst_data_out", data_out, 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_resp", 32'(rsp_resp), 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_rsp_latency", 32'(rsp_latency), 32'd0);
        check("rst_spurious", 32'(spurious_resp), 32'd0);
        reset_n = 1'b1;
        @(negedge c_clk);

        // Directed operations
        run_op(4'd1, 32'h1, 32'h1FFFFFFF, 2, 0);
        run_op(4'd1, 32'hFFFFFFFF, 32'h1, 0, 0);
        run_op(4'd2, 32'h1, 32'hF, 4, 0);
        run_op(4'd3, 32'h1, 32'h1, 1, 0);
        run_op(4'd4, 32'h1, 32'h1, 1, 0);
        run_op(4'd1, 32'h5, 32'h6, TO, 0);
        run_op(4'd2, 32'h10, 32'h3, TO - 1, 0);
        run_op(4'd5, 32'h3, 32'h4, 3, 5);
        run_op(4'd0, 32'h1234, 32'h5678, 0, 2);

        // Randomized operations
        for (int n = 0; n < 30; n++) begin
            rc = cmd_tab[$urandom_range(0, 10)];
            ra = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 40));
            rb = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 40));
            rd = ($urandom_range(0, 9) == 0) ? TO : int'($urandom_range(0, 20));
            run_op(rc, ra, rb, rd, int'($urandom_range(0, 3)));
        end

        // Stray response in IDLE is flagged but the driver stays idle
        calc_resp_in = 2'd2;
        @(negedge c_clk);
        calc_resp_in = 2'd0;
        check("spur_set", 32'(spurious_resp), 32'd1);
        check("spur_req_ready", 32'(req_ready), 32'd1);
        check("spur_rsp_valid", 32'(rsp_valid), 32'd0);
        exp_spurious = 1'b1;
        run_op(4'd1, 32'h7, 32'h8, 1, 0);

        // Reset during SEND1 clears the bus immediately
        req_valid = 1'b1; req_cmd = 4'd1; req_op1 = 32'hAA; req_op2 = 32'hBB;
        @(negedge c_clk);
        req_valid = 1'b0;
        check("send1_before_rst", 32'(cmd_out), 32'd1);
        reset_n = 1'b0;
        #1;
        check("rst_send1_cmd_out", 32'(cmd_out), 32'd0);
        check("rst_send1_data_out", data_out, 32'd0);
        @(negedge c_clk);
        reset_n = 1'b1;
        @(negedge c_clk);

        // Reset during WAIT abandons the operation
        req_valid = 1'b1; req_cmd = 4'd1; req_op1 = 32'h5; req_op2 = 32'h6;
        @(negedge c_clk);
        req_valid = 1'b0;
        repeat (4) @(negedge c_clk);
        reset_n = 1'b0;
        #1;
        check("rst_wait_cmd_out", 32'(cmd_out), 32'd0);
        check("rst_wait_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_wait_spurious", 32'(spurious_resp), 32'd0);
        exp_spurious = 1'b0;
        @(negedge c_clk);
        reset_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge c_clk);
            check("no_result_after_rst", 32'(rsp_valid), 32'd0);
        end
        run_op(4'd0, 32'h0, 32'h0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
